// File: rtl/t_ff_counter_pkg.sv
// rtl/t_ff_counter_pkg.sv - shared encodings, load clamp and next-action type for the T flip-flop counter
package t_ff_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // What the counter does on the coming edge; chosen before toggles are formed
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    LOAD = 2'd1,
    STEP = 2'd2,
    WRAP = 2'd3
  } action_e;

  // Load values at or above the modulus are pinned to the top of the count range
  function automatic logic [15:0] clamp_load(input logic [15:0] value, input logic [16:0] modulus);
    logic [16:0] top;
    top = modulus - 17'd1;
    if ({1'b0, value} < modulus) begin
      return value;
    end
    return top[15:0];
  endfunction

endpackage

// File: rtl/t_ff_cell.sv
// rtl/t_ff_cell.sv - single T flip-flop with synchronous active-high clear
import t_ff_counter_pkg::*;

module t_ff_cell (
  input  logic Clk_In,
  input  logic Reset_In,
  input  logic T_In,
  output logic Q_Out,
  output logic Qb_Out
);

  // Toggle on T, clear on reset
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      Q_Out <= 1'b0;
    end else if (T_In) begin
      Q_Out <= ~Q_Out;
    end
  end

  assign Qb_Out = ~Q_Out;

endmodule

// File: rtl/t_ff_sync_counter.sv
// rtl/t_ff_sync_counter.sv - up/down modulo counter from T cells; T_FF_SYNC_COUNTER_SATURATE_EN selects saturation
import t_ff_counter_pkg::*;

module t_ff_sync_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic             Enable_In,
  input  logic             Up_Down_In,
  input  logic             Load_In,
  input  logic [WIDTH-1:0] Load_Value_In,
  output logic [WIDTH-1:0] Count_Out,
  output logic [WIDTH-1:0] Toggle_Out,
  output logic             Terminal_Count_Out,
  output logic             Wrap_Pulse_Out
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] count_b;
  logic [15:0]      clamp_full;
  logic [WIDTH-1:0] load_target;
  logic             at_terminal;
  action_e          action;

  // Count state is held only in the T cells; the inverted outputs feed the down-count chain
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .Clk_In  (Clk_In),
      .Reset_In(Reset_In),
      .T_In    (Toggle_Out[i]),
      .Q_Out   (Count_Out[i]),
      .Qb_Out  (count_b[i])
    );
  end

  assign clamp_full  = clamp_load(16'(Load_Value_In), 17'(MOD));
  assign load_target = clamp_full[WIDTH-1:0];
  assign at_terminal = (Up_Down_In == DIR_UP) ? (Count_Out == TOP) : (Count_Out == '0);

  // Terminal flag only when a step would actually be taken this cycle
  assign Terminal_Count_Out = ~Reset_In & Enable_In & ~Load_In & at_terminal;

  // Pick the action in priority order: reset, load, enable, hold
  always_comb begin
    action = HOLD;
    if (Reset_In) begin
      action = HOLD;
    end else if (Load_In) begin
      action = LOAD;
    end else if (Enable_In) begin
      action = at_terminal ? WRAP : STEP;
    end
  end

  // Form the toggle vector; carries ripple through ones (up) or zeros (down) of lower bits
  always_comb begin
    logic carry_up;
    logic carry_dn;
    Toggle_Out = '0;
    carry_up   = 1'b1;
    carry_dn   = 1'b1;
    case (action)
      LOAD: Toggle_Out = Count_Out ^ load_target;
      STEP: begin
        for (int i = 0; i < WIDTH; i++) begin
          Toggle_Out[i] = (Up_Down_In == DIR_UP) ? carry_up : carry_dn;
          carry_up = carry_up & Count_Out[i];
          carry_dn = carry_dn & count_b[i];
        end
      end
`ifdef T_FF_SYNC_COUNTER_SATURATE_EN
      WRAP: Toggle_Out = '0;
`else
      WRAP: Toggle_Out = (Up_Down_In == DIR_UP) ? Count_Out : TOP;
`endif
      default: Toggle_Out = '0;
    endcase
  end

  // One-cycle flag after every wrap (or saturation attempt)
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      Wrap_Pulse_Out <= 1'b0;
    end else begin
      Wrap_Pulse_Out <= (action == WRAP);
    end
  end

endmodule

// File: tb/tb_t_ff_sync_counter.sv
// tb/tb_t_ff_sync_counter.sv - directed vector bench for t_ff_sync_counter (WIDTH=4, MOD=10)
module tb_t_ff_sync_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       ld = 1'b0;
  logic [3:0] lv = 4'd0;
  logic [3:0] count;
  logic [3:0] tog;
  logic       tc;
  logic       wrap;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic       ld;
    logic [3:0] lv;
    logic [3:0] tog;
    logic       tc;
    logic [3:0] cnt;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  t_ff_sync_counter #(.WIDTH(4), .MOD(10)) dut (
    .Clk_In            (clk),
    .Reset_In          (rst),
    .Enable_In         (en),
    .Up_Down_In        (up),
    .Load_In           (ld),
    .Load_Value_In     (lv),
    .Count_Out         (count),
    .Toggle_Out        (tog),
    .Terminal_Count_Out(tc),
    .Wrap_Pulse_Out    (wrap)
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic u, input logic l, input logic [3:0] v,
                     input logic [3:0] t, input logic c, input logic [3:0] n, input logic w);
    vec_t x;
    x.rst = r; x.en = e; x.up = u; x.ld = l; x.lv = v;
    x.tog = t; x.tc = c; x.cnt = n; x.wrap = w;
    vecs.push_back(x);
  endtask

  // Drive one cycle: check combinational outputs before the edge, registered ones after it
  task automatic step(input logic r, input logic e, input logic u, input logic l, input logic [3:0] v,
                      input logic [3:0] t, input logic c, input logic [3:0] n, input logic w, input string tag);
    rst = r; en = e; up = u; ld = l; lv = v;
    #1;
    check({tag, ".toggle"}, tog, t);
    check({tag, ".terminal"}, {3'b0, tc}, {3'b0, c});
    @(posedge clk);
    #1;
    check({tag, ".count"}, count, n);
    check({tag, ".wrap"}, {3'b0, wrap}, {3'b0, w});
  endtask

  initial begin
    int c;
    // reset with enable high
    add(1, 1, 1, 0, 4'd0, 4'b0000, 0, 4'd0, 0);
    add(1, 1, 1, 0, 4'd0, 4'b0000, 0, 4'd0, 0);
    // up count 0 -> 1..9,0,1,2
    add(0, 1, 1, 0, 4'd0, 4'b0001, 0, 4'd1, 0);
    add(0, 1, 1, 0, 4'd0, 4'b0011, 0, 4'd2, 0);
    add(0, 1, 1, 0, 4'd0, 4'b0001, 0, 4'd3, 0);
    add(0, 1, 1, 0, 4'd0, 4'b0111, 0, 4'd4, 0);
    add(0, 1, 1, 0, 4'd0, 4'b0001, 0, 4'd5, 0);
    add(0, 1, 1, 0, 4'd0, 4'b0011, 0, 4'd6, 0);
    add(0, 1, 1, 0, 4'd0, 4'b0001, 0, 4'd7, 0);
    add(0, 1, 1, 0, 4'd0, 4'b1111, 0, 4'd8, 0);
    add(0, 1, 1, 0, 4'd0, 4'b0001, 0, 4'd9, 0);
    add(0, 1, 1, 0, 4'd0, 4'b1001, 1, 4'd0, 1);
    add(0, 1, 1, 0, 4'd0, 4'b0001, 0, 4'd1, 0);
    add(0, 1, 1, 0, 4'd0, 4'b0011, 0, 4'd2, 0);
    // down from 2 -> 1,0,9,8
    add(0, 1, 0, 0, 4'd0, 4'b0011, 0, 4'd1, 0);
    add(0, 1, 0, 0, 4'd0, 4'b0001, 0, 4'd0, 0);
    add(0, 1, 0, 0, 4'd0, 4'b1001, 1, 4'd9, 1);
    add(0, 1, 0, 0, 4'd0, 4'b0001, 0, 4'd8, 0);
    // load beats enable; out-of-range load clamps to 9; load at terminal suppresses the flag
    add(0, 1, 1, 1, 4'd6, 4'b1110, 0, 4'd6, 0);
    add(0, 1, 1, 1, 4'd13, 4'b1111, 0, 4'd9, 0);
    add(0, 1, 1, 1, 4'd5, 4'b1100, 0, 4'd5, 0);
    // direction flips every cycle
    add(0, 1, 1, 0, 4'd0, 4'b0011, 0, 4'd6, 0);
    add(0, 1, 0, 0, 4'd0, 4'b0011, 0, 4'd5, 0);
    add(0, 1, 1, 0, 4'd0, 4'b0011, 0, 4'd6, 0);
    add(0, 1, 0, 0, 4'd0, 4'b0011, 0, 4'd5, 0);
    // hold
    add(0, 0, 1, 0, 4'd0, 4'b0000, 0, 4'd5, 0);
    add(0, 0, 0, 0, 4'd0, 4'b0000, 0, 4'd5, 0);
    add(0, 0, 1, 0, 4'd0, 4'b0000, 0, 4'd5, 0);
    // reset overrides a load; then down-wrap from 0; pulse lasts one cycle
    add(1, 1, 1, 1, 4'd3, 4'b0000, 0, 4'd0, 0);
    add(0, 1, 0, 0, 4'd0, 4'b1001, 1, 4'd9, 1);
    add(0, 0, 0, 0, 4'd0, 4'b0000, 0, 4'd9, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].ld, vecs[i].lv,
           vecs[i].tog, vecs[i].tc, vecs[i].cnt, vecs[i].wrap, $sformatf("vec%0d", i));
    end

    // long up run against a simple modulo model; wrap must follow each 9 -> 0
    step(0, 0, 1, 1, 4'd0, 4'b1001, 0, 4'd0, 0, "seq_load0");
    c = 0;
    for (int k = 0; k < 25; k++) begin
      rst = 0; en = 1; up = 1; ld = 0;
      @(posedge clk);
      #1;
      check($sformatf("run%0d.count", k), count, 4'((c + 1) % 10));
      check($sformatf("run%0d.wrap", k), {3'b0, wrap}, {3'b0, (c == 9)});
      c = (c + 1) % 10;
    end

`ifdef T_FF_SYNC_COUNTER_SATURATE_EN
    // saturating up count from 8, then reversing releases it
    step(0, 1, 1, 1, 4'd8, 4'(c) ^ 4'd8, 0, 4'd8, 0, "sat_load");
    step(0, 1, 1, 0, 4'd0, 4'b0001, 0, 4'd9, 0, "sat1");
    step(0, 1, 1, 0, 4'd0, 4'b0000, 1, 4'd9, 1, "sat2");
    step(0, 1, 1, 0, 4'd0, 4'b0000, 1, 4'd9, 1, "sat3");
    step(0, 1, 0, 0, 4'd0, 4'b0001, 0, 4'd8, 0, "sat_rev");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
